sprite_rom_arbiter: RTL and testbench

//   Shares one sprite ROM read port among the four sprite renderers: dino, obstacle 1, obstacle 2
//   and background object. Each renderer presents a request and a ROM counter. The block grants
//   one requester per cycle in round-robin order and drives the shared ROM address.

---
 rtl/dino_pkg.sv | 22 ++
 rtl/rr_pick.sv | 38 +++
 rtl/sprite_rom_arbiter.sv | 152 +++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dino_pkg
//  Description : Shared sprite-path constants. Holds the requester IDs of
//                the four sprite renderers and the sprite ROM address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dino_pkg;

    // Renderer IDs; the value is the bit position in every per-requester bus
    typedef enum logic [1:0] {
        REQ_DINO = 2'd0,
        REQ_OBS1 = 2'd1,
        REQ_OBS2 = 2'd2,
        REQ_BG   = 2'd3
    } req_id_e;

    localparam int NUM_SPRITE_REQ = 4;
    localparam int SPRITE_ADDR_W  = 8;

endpackage : dino_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set bit
//                of the eligible mask at or above the pointer, wrapping round
//                to bit 0, as a one-hot vector plus an any-valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic               o_any
);

    // Scan the upper part (ptr..N-1) first, then wrap to the lower part (0..ptr-1)
    always_comb begin
        o_onehot = '0;
        o_any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_mask[i] && (i >= int'(i_ptr))) begin
                o_onehot[i] = 1'b1;
                o_any       = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_mask[i] && (i < int'(i_ptr))) begin
                o_onehot[i] = 1'b1;
                o_any       = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_arbiter
//  Description : Shares one sprite ROM read port between the sprite
//                renderers. Round-robin grant (never the same requester on
//                consecutive cycles), registered ROM address, a latency pipe
//                tagging each read with its requester, and per-requester
//                pixel holding registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter
    import dino_pkg::*;
#(
    parameter int NUM_REQ     = NUM_SPRITE_REQ,
    parameter int ADDR_W      = SPRITE_ADDR_W,
    parameter int ROM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_rom_en,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic                      i_rom_data,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [NUM_REQ-1:0]        o_sprite_color
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Grant stage
    logic [NUM_REQ-1:0] r_grant;
    logic [c_PTR_W-1:0] r_grant_id;
    logic               r_rom_en;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [c_PTR_W-1:0] r_ptr;

    // Latency pipe: one {valid, id} slot per ROM cycle
    logic               r_pipe_vld [ROM_LATENCY];
    logic [c_PTR_W-1:0] r_pipe_id  [ROM_LATENCY];

    // Return stage
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [NUM_REQ-1:0] r_color;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic               w_win_any;
    logic [c_PTR_W-1:0] w_win_idx;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic               w_ret_vld;
    logic [c_PTR_W-1:0] w_ret_id;

    // The requester granted last cycle is masked out; this covers its handshake delay
    assign w_eligible = i_req & ~r_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_pick (
        .i_mask   (w_eligible),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_any    (w_win_any)
    );

    // Winner index and its address, decoded from the one-hot pick
    always_comb begin
        w_win_idx  = '0;
        w_win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_onehot[i]) begin
                w_win_idx  = c_PTR_W'(i);
                w_win_addr = i_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_ptr_next = (int'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + c_PTR_W'(1);

    // Arbitration: register the winner, its address and the advanced pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_ptr      <= '0;
        end else if (i_flush) begin
            r_grant  <= '0;
            r_rom_en <= 1'b0;
            r_ptr    <= '0;
        end else if (w_win_any) begin
            r_grant    <= w_win_onehot;
            r_grant_id <= w_win_idx;
            r_rom_en   <= 1'b1;
            r_rom_addr <= w_win_addr;
            r_ptr      <= w_ptr_next;
        end else begin
            r_grant  <= '0;
            r_rom_en <= 1'b0;
        end
    end

    // Latency pipe: tag each issued read with its requester until the ROM answers
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_id[i]  <= '0;
            end
        end else begin
            r_pipe_vld[0] <= r_rom_en;
            r_pipe_id[0]  <= r_grant_id;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    assign w_ret_vld = r_pipe_vld[ROM_LATENCY-1];
    assign w_ret_id  = r_pipe_id[ROM_LATENCY-1];

    // Return path: steer the ROM pixel into the owner's holding register and pulse its valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_color     <= '0;
        end else if (i_flush) begin
            r_rsp_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rsp_valid[i] <= w_ret_vld && (w_ret_id == c_PTR_W'(i));
                if (w_ret_vld && (w_ret_id == c_PTR_W'(i))) begin
                    r_color[i] <= i_rom_data;
                end
            end
        end
    end

    assign o_grant        = r_grant;
    assign o_rom_en       = r_rom_en;
    assign o_rom_addr     = r_rom_addr;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_sprite_color = r_color;

endmodule : sprite_rom_arbiter
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_rom_arbiter
//  Description : Self-checking bench. dut (ROM_LATENCY=1) is tracked every
//                cycle by a transaction-level model (round-robin search plus
//                a queue of pending reads with due times); dut2
//                (ROM_LATENCY=2) covers the flush scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, flush2;
    logic [3:0]  req, req2;
    logic [31:0] addr, addr2;

    logic [3:0]  o_grant, g2;
    logic        o_rom_en, en2;
    logic [7:0]  o_rom_addr, a2;
    logic [3:0]  o_rsp_valid, rsp2;
    logic [3:0]  o_color, col2;
    logic        rom1_q;
    logic        rom2_a, rom2_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .ROM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .i_req(req), .i_addr(addr),
        .o_grant(o_grant), .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr),
        .i_rom_data(rom1_q), .o_rsp_valid(o_rsp_valid), .o_sprite_color(o_color)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .ROM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .i_flush(flush2), .i_req(req2), .i_addr(addr2),
        .o_grant(g2), .o_rom_en(en2), .o_rom_addr(a2),
        .i_rom_data(rom2_q), .o_rsp_valid(rsp2), .o_sprite_color(col2)
    );

    // Synchronous sprite ROMs: pixel = address bit 0
    always @(posedge clk) begin
        if (o_rom_en) rom1_q <= o_rom_addr[0];
        if (en2) rom2_a <= a2[0];
        rom2_q <= rom2_a;
    end

    // ---------------- reference model for dut (ROM_LATENCY = 1) -----------------
    typedef struct { int due; int id; logic val; } pend_t;
    pend_t      pend[$];
    int         cyc = 0;
    int         m_ptr = 0;
    logic [3:0] m_grant = '0, m_rsp = '0, m_color = '0;
    logic       m_en = 1'b0;
    logic [7:0] m_addr = '0;

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_grant = '0; m_en = 1'b0; m_addr = '0; m_ptr = 0; m_rsp = '0; m_color = '0;
            pend.delete();
        end else if (flush) begin
            m_grant = '0; m_en = 1'b0; m_ptr = 0; m_rsp = '0;
            pend.delete();
        end else begin
            logic [3:0] elig;
            int w;
            m_rsp = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                pend_t p;
                p = pend.pop_front();
                m_rsp[p.id]   = 1'b1;
                m_color[p.id] = p.val;
            end
            elig = req & ~m_grant;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (w < 0 && elig[c]) w = c;
            end
            if (w >= 0) begin
                m_grant = 4'b0001 << w;
                m_en    = 1'b1;
                m_addr  = addr[w*8 +: 8];
                m_ptr   = (w + 1) % 4;
                pend.push_back('{cyc + 2, w, addr[w*8]});
            end else begin
                m_grant = '0;
                m_en    = 1'b0;
            end
        end
        #1;
    endtask

    // ------------------------------- tests --------------------------------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; flush2 = 1'b0;
        req = 4'b1111; addr = $urandom; req2 = '0; addr2 = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color} !== 21'd0 ||
                {g2, en2, a2, rsp2, col2} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h / %h, want 0",
                         {o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color},
                         {g2, en2, a2, rsp2, col2});
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (o_grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_grant: got %b want 0001", o_grant);
        end
    endtask

    task automatic test_all_request();
        logic [3:0] exp_g, exp_r;
        req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 4; i++)
                if (m_grant[i]) addr[i*8 +: 8] = 8'($urandom);
            tick();
            exp_g = 4'b0001 << ((1 + k) % 4);
            exp_r = 4'b0001 << ((k + 3) % 4);
            n_checks++;
            if (o_grant !== exp_g) begin
                n_fail++;
                $display("FAIL all_req_grant k=%0d: got %b want %b", k, o_grant, exp_g);
            end
            if (k >= 1) begin
                n_checks++;
                if (o_rsp_valid !== exp_r) begin
                    n_fail++;
                    $display("FAIL all_req_rsp k=%0d: got %b want %b", k, o_rsp_valid, exp_r);
                end
            end
            n_checks++;
            if ({o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color} !==
                {m_grant, m_en, m_addr, m_rsp, m_color}) begin
                n_fail++;
                $display("FAIL all_req_model cyc=%0d: got %h want %h", cyc,
                         {o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color},
                         {m_grant, m_en, m_addr, m_rsp, m_color});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            req   = 4'($urandom_range(0, 15));
            flush = ($urandom_range(0, 15) == 0);
            addr  = $urandom;
            tick();
            n_checks++;
            if ({o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color} !==
                {m_grant, m_en, m_addr, m_rsp, m_color}) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d: got %h want %h", cyc,
                         {o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color},
                         {m_grant, m_en, m_addr, m_rsp, m_color});
            end
            n_checks++;
            if (o_rom_en !== (|o_grant) || !$onehot0(o_grant) || !$onehot0(o_rsp_valid)) begin
                n_fail++;
                $display("FAIL random_invariants cyc=%0d: grant=%b en=%b rsp=%b",
                         cyc, o_grant, o_rom_en, o_rsp_valid);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_lone();
        logic [3:0] exp_g;
        req = '0; flush = 1'b1;
        tick();
        flush = 1'b0;
        req = 4'b0100;
        addr = $urandom;
        addr[23:16] = 8'h3C;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_g = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (o_grant !== exp_g || o_rom_addr !== 8'h3C) begin
                n_fail++;
                $display("FAIL lone_grant k=%0d: got grant=%b addr=%h want grant=%b addr=3c",
                         k, o_grant, o_rom_addr, exp_g);
            end
            n_checks++;
            if ({o_rsp_valid, o_color} !== {m_rsp, m_color}) begin
                n_fail++;
                $display("FAIL lone_rsp k=%0d: got %h want %h", k,
                         {o_rsp_valid, o_color}, {m_rsp, m_color});
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] reqs [4] = '{4'b1000, 4'b0011, 4'b0010, 4'b0000};
        logic [3:0] exps [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0000};
        req = '0; flush = 1'b1;
        tick();
        flush = 1'b0;
        addr = $urandom;
        for (int k = 0; k < 4; k++) begin
            req = reqs[k];
            tick();
            n_checks++;
            if (o_grant !== exps[k] || o_grant !== m_grant) begin
                n_fail++;
                $display("FAIL fairness k=%0d: got %b want %b", k, o_grant, exps[k]);
            end
        end
    endtask

    task automatic test_flush_lat2();
        int seen_at, pulses;
        req = '0;
        // Plain read on dut2 first so that colour[1] holds 1
        req2 = 4'b0010; addr2 = '0; addr2[15:8] = 8'h01;
        tick();
        n_checks++;
        if (g2 !== 4'b0010 || a2 !== 8'h01) begin
            n_fail++;
            $display("FAIL lat2_grant: got grant=%b addr=%h want 0010/01", g2, a2);
        end
        req2 = '0;
        seen_at = -1; pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (rsp2 !== 4'b0000) pulses++;
            if (rsp2 === 4'b0010 && seen_at < 0) seen_at = i;
        end
        n_checks++;
        if (seen_at != 3 || pulses != 1 || col2[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL lat2_latency: got edge=%0d pulses=%0d color1=%b want 3/1/1",
                     seen_at, pulses, col2[1]);
        end
        // Grant requester 1 with a 0 pixel, then flush one edge later
        req2 = 4'b0010; addr2[15:8] = 8'h02;
        tick();
        n_checks++;
        if (g2 !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_pre_grant: got %b want 0010", g2);
        end
        req2 = '0; flush2 = 1'b1;
        tick();
        n_checks++;
        if (g2 !== 4'b0000 || en2 !== 1'b0 || rsp2 !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_edge: got grant=%b en=%b rsp=%b want 0", g2, en2, rsp2);
        end
        flush2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (rsp2 !== 4'b0000 || col2[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_no_rsp i=%0d: got rsp=%b color1=%b want 0000/1",
                         i, rsp2, col2[1]);
            end
        end
        req2 = 4'b1010;
        tick();
        n_checks++;
        if (g2 !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_ptr: got %b want 0010", g2);
        end
        req2 = '0;
        tick();
    endtask

    task automatic test_mid_reset();
        req = 4'b1111; req2 = 4'b1111;
        addr = $urandom; addr2 = $urandom;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color} !== 21'd0 ||
            {g2, en2, a2, rsp2, col2} !== 21'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h / %h want 0",
                     {o_grant, o_rom_en, o_rom_addr, o_rsp_valid, o_color},
                     {g2, en2, a2, rsp2, col2});
        end
        rst = 1'b0; req = '0; req2 = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (o_rsp_valid !== 4'b0000 || o_color !== 4'b0000 ||
                rsp2 !== 4'b0000 || col2 !== 4'b0000) begin
                n_fail++;
                $display("FAIL post_reset k=%0d: got rsp=%b col=%b rsp2=%b col2=%b want 0",
                         k, o_rsp_valid, o_color, rsp2, col2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_request();
        test_random();
        test_lone();
        test_fairness();
        test_flush_lat2();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_sprite_rom_arbiter
`default_nettype wire
